// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and output-buffer state type for the FIFO read stage.
package fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    typedef enum logic [1:0] {OB_EMPTY, OB_ONE, OB_TWO} obuf_state_t;
endpackage

// File: rtl/fifo_mem_array.sv
// fifo_mem_array: DEPTH x DATA_W storage, one write port, one registered read-first read port.
import fifo_pkg::*;
module fifo_mem_array #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // Non-blocking read and write on the same edge gives read-first behaviour
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_ptr];
    end
endmodule

// File: rtl/fifo_read_stage.sv
// fifo_read_stage: FIFO storage plus credit-controlled drain into a 2-entry valid/ready buffer,
// with occupancy tracking and sticky overflow/underflow flags.
import fifo_pkg::*;
module fifo_read_stage #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_ptr,
    input  logic              emp,
    output logic              rd_req,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   level,
    output logic              ovf_err,
    output logic              udf_err,
    input  logic              clr_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    obuf_state_t       state;
    logic              run;
    logic              p_valid;
    logic [DATA_W-1:0] p_data;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              take;
    logic [1:0]        buf_count;
    logic [2:0]        occ;

    fifo_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk),
        .wr_en(wr_en),
        .wr_ptr(wr_ptr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_ptr(rd_ptr),
        .rd_data(p_data)
    );

    // occ is the buffer fill after this edge; requesting only below 2 keeps TWO from ever seeing a new word
    always_comb begin
        take      = m_valid & m_ready;
        buf_count = state == OB_TWO ? 2'd2 : state == OB_ONE ? 2'd1 : 2'd0;
        occ       = {1'b0, buf_count} + {2'b0, p_valid} - {2'b0, take};
        rd_req    = run & ~emp & (occ < 3'd2);
    end

    assign m_valid = state != OB_EMPTY;
    assign m_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            p_valid <= 1'b0;
            state   <= OB_EMPTY;
            head    <= '0;
            tail    <= '0;
            level   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            run     <= 1'b1;
            p_valid <= rd_en;
            case (state)
                OB_EMPTY: if (p_valid) begin
                    head  <= p_data;
                    state <= OB_ONE;
                end
                OB_ONE: if (p_valid && take) begin
                    head <= p_data;
                end else if (p_valid) begin
                    tail  <= p_data;
                    state <= OB_TWO;
                end else if (take) begin
                    state <= OB_EMPTY;
                end
                OB_TWO: if (take) begin
                    head  <= tail;
                    state <= OB_ONE;
                end
                default: state <= OB_EMPTY;
            endcase
            if (wr_en && !rd_en && level != FULL)
                level <= level + 1'b1;
            else if (rd_en && !wr_en && level != '0)
                level <= level - 1'b1;
            ovf_err <= (wr_en & (level == FULL)) | (ovf_err & ~clr_err);
            udf_err <= (rd_en & (level == '0)) | (udf_err & ~clr_err);
        end
    end

    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == OB_TWO && p_valid && !take));
endmodule

// File: tb/tb_fifo_read_stage.sv
// tb_fifo_read_stage: directed checks of reset, single read, streaming, backpressure,
// level/error boundaries and same-address read-first behaviour.
module tb_fifo_read_stage;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       wr_en = 0;
    logic [4:0] wr_ptr = 0;
    logic [7:0] wr_data = 0;
    logic       rd_en = 0;
    logic [4:0] rd_ptr = 0;
    logic       emp = 1;
    logic       rd_req;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 0;
    logic [5:0] level;
    logic       ovf_err;
    logic       udf_err;
    logic       clr_err = 0;

    int pass = 0;
    int total = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    fifo_read_stage dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ptr(rd_ptr), .emp(emp), .rd_req(rd_req), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .level(level), .ovf_err(ovf_err),
        .udf_err(udf_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 0; wr_en = 0; rd_en = 0; m_ready = 0; clr_err = 0; emp = 1;
        rd_cnt = 0; wr_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic write_word(input logic [4:0] p, input logic [7:0] d);
        wr_en = 1; wr_ptr = p; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    // Acts as the controller for one cycle: grants rd_en whenever the stage requests
    task automatic ctrl_cycle(input logic rdy, output logic took, output logic [7:0] d,
                              output logic req);
        rd_en = 0;
        emp = (rd_cnt == wr_cnt);
        m_ready = rdy;
        #1;
        took = m_valid & m_ready;
        d = m_data;
        req = rd_req;
        rd_en = rd_req;
        rd_ptr = 5'(rd_cnt % 32);
        @(posedge clk);
        if (rd_en) rd_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic took, req;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) write_word(5'(i), 8'(8'h60 + i));
        wr_cnt = 3;
        for (int i = 0; i < 4; i++) ctrl_cycle(0, took, d, req);
        rd_en = 0;
        total++; if (m_valid !== 1'b1) $display("FAIL reset_pre_two m_valid=%0b want 1", m_valid); else pass++;
        rst_n = 0; emp = 0;
        #1;
        total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%0b want 0", m_valid); else pass++;
        total++; if (level !== 6'd0) $display("FAIL reset_level got=%0d want 0", level); else pass++;
        total++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req got=%0b want 0", rd_req); else pass++;
        total++; if ({ovf_err, udf_err, m_data} !== 10'd0) $display("FAIL reset_err_data got=%0h want 0", {ovf_err, udf_err, m_data}); else pass++;
        @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (rd_req !== 1'b0) $display("FAIL reset_first_cycle_rd_req got=%0b want 0", rd_req); else pass++;
        @(posedge clk);
        #1;
        total++; if (rd_req !== 1'b1) $display("FAIL reset_run_rd_req got=%0b want 1", rd_req); else pass++;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        write_word(5'd3, 8'hA5);
        total++; if (level !== 6'd1) $display("FAIL single_level_after_wr got=%0d want 1", level); else pass++;
        emp = 0; rd_en = 1; rd_ptr = 5'd3;
        #1;
        total++; if (rd_req !== 1'b1) $display("FAIL single_rd_req got=%0b want 1", rd_req); else pass++;
        @(negedge clk);
        rd_en = 0; emp = 1;
        #1;
        total++; if (m_valid !== 1'b0) $display("FAIL single_valid_early got=%0b want 0", m_valid); else pass++;
        total++; if (level !== 6'd0) $display("FAIL single_level_after_rd got=%0d want 0", level); else pass++;
        @(negedge clk);
        #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'hA5) $display("FAIL single_data got=%0b/%02h want 1/a5", m_valid, m_data); else pass++;
        m_ready = 1;
        @(negedge clk);
        #1;
        total++; if (m_valid !== 1'b0) $display("FAIL single_drained got=%0b want 0", m_valid); else pass++;
        m_ready = 0;
    endtask

    task automatic test_stream();
        logic took, req, started;
        logic [7:0] d;
        int exp, gaps;
        do_reset();
        for (int i = 0; i < 32; i++) write_word(5'(i), 8'(i));
        wr_cnt = 32;
        total++; if (level !== 6'd32) $display("FAIL stream_level_full got=%0d want 32", level); else pass++;
        exp = 0; gaps = 0; started = 0;
        for (int c = 0; c < 200 && exp < 32; c++) begin
            ctrl_cycle(1, took, d, req);
            if (took) begin
                started = 1;
                total++; if (d !== 8'(exp)) $display("FAIL stream_word%0d got=%02h want %02h", exp, d, 8'(exp)); else pass++;
                exp++;
            end else if (started) gaps++;
        end
        rd_en = 0; m_ready = 0;
        total++; if (exp !== 32) $display("FAIL stream_count got=%0d want 32", exp); else pass++;
        total++; if (gaps !== 0) $display("FAIL stream_gaps got=%0d want 0", gaps); else pass++;
        total++; if (level !== 6'd0) $display("FAIL stream_level_end got=%0d want 0", level); else pass++;
    endtask

    task automatic test_backpressure();
        logic took, req;
        logic [7:0] d, held;
        int exp;
        do_reset();
        for (int i = 0; i < 20; i++) write_word(5'(i), 8'(8'h40 + i));
        wr_cnt = 20;
        exp = 0; held = 0;
        for (int c = 0; c < 200 && exp < 20; c++) begin
            ctrl_cycle(!(c >= 5 && c < 15), took, d, req);
            if (c == 6) held = d;
            if (c == 14) begin
                total++; if (req !== 1'b0) $display("FAIL bp_rd_req_stall got=%0b want 0", req); else pass++;
                total++; if (d !== held) $display("FAIL bp_data_stable got=%02h want %02h", d, held); else pass++;
                total++; if (d !== 8'(8'h40 + exp)) $display("FAIL bp_head_word got=%02h want %02h", d, 8'(8'h40 + exp)); else pass++;
            end
            if (took) begin
                total++; if (d !== 8'(8'h40 + exp)) $display("FAIL bp_word%0d got=%02h want %02h", exp, d, 8'(8'h40 + exp)); else pass++;
                exp++;
            end
        end
        rd_en = 0; m_ready = 0;
        total++; if (exp !== 20) $display("FAIL bp_count got=%0d want 20", exp); else pass++;
        total++; if (level !== 6'd0) $display("FAIL bp_level_end got=%0d want 0", level); else pass++;
    endtask

    task automatic test_boundary();
        logic took, req;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 33; i++) begin
            write_word(5'(i % 32), 8'(i));
            if (i == 31) begin
                total++; if (level !== 6'd32 || ovf_err !== 1'b0) $display("FAIL bnd_full got=%0d/%0b want 32/0", level, ovf_err); else pass++;
            end
        end
        total++; if (level !== 6'd32 || ovf_err !== 1'b1) $display("FAIL bnd_ovf got=%0d/%0b want 32/1", level, ovf_err); else pass++;
        wr_cnt = 32;
        for (int c = 0; c < 200 && rd_cnt < 32; c++) ctrl_cycle(1, took, d, req);
        for (int c = 0; c < 3; c++) ctrl_cycle(1, took, d, req);
        rd_en = 0;
        total++; if (level !== 6'd0 || udf_err !== 1'b0) $display("FAIL bnd_drained got=%0d/%0b want 0/0", level, udf_err); else pass++;
        m_ready = 1; rd_en = 1; rd_ptr = 0;
        @(negedge clk);
        rd_en = 0;
        #1;
        total++; if (udf_err !== 1'b1 || ovf_err !== 1'b1 || level !== 6'd0) $display("FAIL bnd_udf got=%0b/%0b/%0d want 1/1/0", udf_err, ovf_err, level); else pass++;
        @(negedge clk);
        clr_err = 1; rd_en = 1;
        @(negedge clk);
        clr_err = 0; rd_en = 0;
        #1;
        total++; if (udf_err !== 1'b1 || ovf_err !== 1'b0) $display("FAIL bnd_set_wins got=%0b/%0b want 1/0", udf_err, ovf_err); else pass++;
        @(negedge clk);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        #1;
        total++; if (udf_err !== 1'b0 || ovf_err !== 1'b0) $display("FAIL bnd_clear got=%0b/%0b want 0/0", udf_err, ovf_err); else pass++;
        m_ready = 0;
    endtask

    task automatic test_same_addr();
        do_reset();
        write_word(5'd7, 8'h11);
        wr_en = 1; wr_ptr = 5'd7; wr_data = 8'h22;
        rd_en = 1; rd_ptr = 5'd7; emp = 0;
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        #1;
        total++; if (level !== 6'd1) $display("FAIL same_level got=%0d want 1", level); else pass++;
        @(negedge clk);
        #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'h11) $display("FAIL same_old_data got=%0b/%02h want 1/11", m_valid, m_data); else pass++;
        m_ready = 1; rd_en = 1; rd_ptr = 5'd7;
        @(negedge clk);
        m_ready = 0; rd_en = 0; emp = 1;
        #1;
        total++; if (level !== 6'd0 || m_valid !== 1'b0) $display("FAIL same_after_take got=%0d/%0b want 0/0", level, m_valid); else pass++;
        @(negedge clk);
        #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'h22) $display("FAIL same_new_data got=%0b/%02h want 1/22", m_valid, m_data); else pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_boundary();
        test_same_addr();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
